// File: rtl/update_sequencer_pkg.sv
// rtl/update_sequencer_pkg.sv - shared sizes, update record and sequencer state encoding
package update_sequencer_pkg;

    localparam int NODES    = 32;
    localparam int PRED_W   = 5;
    localparam int WEIGHT_W = 32;
    localparam int DEPTH    = 8;
    localparam int PTR_W    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PRED_W-1:0]   src;
        logic [PRED_W-1:0]   dst;
        logic [WEIGHT_W-1:0] e;
    } update_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT
    } state_t;

    function automatic logic idx_ok(input logic [PRED_W-1:0] v);
        return int'(v) < NODES;
    endfunction

endpackage

// File: rtl/update_sequencer_if.sv
// rtl/update_sequencer_if.sv - host-side edge-update write bus
interface update_sequencer_if;
    import update_sequencer_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [PRED_W-1:0]   wr_src;
    logic [PRED_W-1:0]   wr_dst;
    logic [WEIGHT_W-1:0] wr_e;

    modport master (
        output wr_valid, wr_src, wr_dst, wr_e,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_src, wr_dst, wr_e,
        output wr_ready
    );

endinterface

// File: rtl/update_sequencer_fifo.sv
// rtl/update_sequencer_fifo.sv - DEPTH-entry update FIFO with tail peek and tail weight overwrite
module update_fifo
    import update_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                push_i,
    input  update_t             data_i,
    input  logic                pop_i,
    input  logic                overwrite_i,
    input  logic [WEIGHT_W-1:0] weight_i,
    output update_t             head_o,
    output logic [PRED_W-1:0]   tail_src_o,
    output logic [PRED_W-1:0]   tail_dst_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [PTR_W-1:0]    count_o
);

    update_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-2:0] tail_idx;

    assign tail_idx   = wptr_q[PTR_W-2:0] - 1'b1;
    assign head_o     = mem_q[rptr_q[PTR_W-2:0]];
    assign tail_src_o = mem_q[tail_idx].src;
    assign tail_dst_o = mem_q[tail_idx].dst;
    assign count_o    = wptr_q - rptr_q;
    assign empty_o    = (wptr_q == rptr_q);
    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign full_o     = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                        (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && (!full_o || pop_i)) begin
                mem_q[wptr_q[PTR_W-2:0]] <= data_i;
                wptr_q <= wptr_q + 1'b1;
            end
            if (overwrite_i) begin
                mem_q[tail_idx].e <= weight_i;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/update_sequencer.sv
// rtl/update_sequencer.sv - queues host edge updates and launches one container run each; UPDATE_COALESCE_EN enables tail coalescing
module update_sequencer
    import update_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                update_reset_n,
    update_sequencer_if.slave   wr,
    input  logic [PRED_W-1:0]   src_cfg,
    input  logic                container_done,
    output logic                container_reset,
    output logic [PRED_W-1:0]   u_src,
    output logic [PRED_W-1:0]   u_dst,
    output logic [WEIGHT_W-1:0] u_e,
    output logic [PRED_W-1:0]   src,
    output logic                busy,
    output logic [15:0]         reject_cnt
);

`ifdef UPDATE_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    state_t            state_q, state_d;
    update_t           cur_q;
    logic [PRED_W-1:0] src_q;
    logic [15:0]       rej_q, rej_d;

    update_t           head;
    update_t           wr_upd;
    logic [PRED_W-1:0] tail_src, tail_dst;
    logic              fifo_full, fifo_empty;
    logic [PTR_W-1:0]  fifo_count;
    logic              pop, tail_hit, idx_valid, accept, push, overwrite, reject;

    assign wr_upd    = '{src: wr.wr_src, dst: wr.wr_dst, e: wr.wr_e};
    assign pop       = (state_q == S_IDLE) && !fifo_empty;
    assign idx_valid = (wr.wr_src != wr.wr_dst) && idx_ok(wr.wr_src) && idx_ok(wr.wr_dst);
    // A sole entry leaving this cycle is already launched, so it may not absorb a write.
    assign tail_hit  = COALESCE && !fifo_empty &&
                       (tail_src == wr.wr_src) && (tail_dst == wr.wr_dst) &&
                       !(pop && fifo_count == PTR_W'(1));
    assign wr.wr_ready = !fifo_full || tail_hit;
    assign accept    = wr.wr_valid && wr.wr_ready;
    assign reject    = accept && !idx_valid;
    assign overwrite = accept && tail_hit;
    assign push      = accept && idx_valid && !tail_hit;

    update_fifo u_fifo (
        .clk         (clk),
        .resetn      (update_reset_n),
        .push_i      (push),
        .data_i      (wr_upd),
        .pop_i       (pop),
        .overwrite_i (overwrite),
        .weight_i    (wr.wr_e),
        .head_o      (head),
        .tail_src_o  (tail_src),
        .tail_dst_o  (tail_dst),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!update_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_ARM;
            S_ARM:    state_d = S_WAIT;
            S_WAIT:   if (container_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        container_reset = (state_q == S_LAUNCH);
        busy            = (state_q != S_IDLE);
    end

    always_comb begin
        rej_d = rej_q;
        if (reject && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!update_reset_n) begin
            cur_q <= '0;
            src_q <= '0;
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
            if (pop) begin
                cur_q <= head;
                src_q <= src_cfg;
            end
        end
    end

    assign u_src      = cur_q.src;
    assign u_dst      = cur_q.dst;
    assign u_e        = cur_q.e;
    assign src        = src_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_update_sequencer.sv
// tb/tb_update_sequencer.sv - directed and randomized checks against a queue-based timing model
module tb_update_sequencer;

    localparam int NODES = 32;
    localparam int DEPTH = 8;
`ifdef UPDATE_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  src_cfg;
    logic        done;
    logic        creset;
    logic [4:0]  u_src, u_dst, srco;
    logic [31:0] u_e;
    logic        busy;
    logic [15:0] rej;

    always #5 clk = ~clk;

    update_sequencer_if wr_if ();

    update_sequencer dut (
        .clk             (clk),
        .update_reset_n  (rstn),
        .wr              (wr_if),
        .src_cfg         (src_cfg),
        .container_done  (done),
        .container_reset (creset),
        .u_src           (u_src),
        .u_dst           (u_dst),
        .u_e             (u_e),
        .src             (srco),
        .busy            (busy),
        .reject_cnt      (rej)
    );

    typedef struct {
        int s;
        int d;
        int e;
    } upd_t;

    upd_t q[$];
    bit   in_run;
    bit   chk_en;
    int   launch_cyc;
    int   cyc;
    int   exp_us, exp_ud, exp_ue, exp_src, exp_rej;
    int   n_checks, n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model past the edge.
    task automatic step(input bit v, input int s, input int d, input int e, input bit dn, input bit rn);
        bit   ready, pop, hit, end_run;
        int   cfg;
        upd_t ent;
        @(negedge clk);
        cfg = int'($urandom_range(0, NODES - 1));
        wr_if.wr_valid = v;
        wr_if.wr_src   = s[4:0];
        wr_if.wr_dst   = d[4:0];
        wr_if.wr_e     = e;
        done           = dn;
        rstn           = rn;
        src_cfg        = cfg[4:0];
        #1;
        pop   = !in_run && q.size() > 0;
        hit   = COAL && q.size() > 0 && q[$].s == s && q[$].d == d && !(pop && q.size() == 1);
        ready = (q.size() < DEPTH) || hit;
        if (chk_en) begin
            check("container_reset", {31'b0, creset}, {31'b0, in_run && cyc == launch_cyc});
            check("busy", {31'b0, busy}, {31'b0, in_run});
            check("wr_ready", {31'b0, wr_if.wr_ready}, {31'b0, ready});
            check("reject_cnt", {16'b0, rej}, exp_rej);
            check("u_src", {27'b0, u_src}, exp_us);
            check("u_dst", {27'b0, u_dst}, exp_ud);
            check("u_e", u_e, exp_ue);
            check("src", {27'b0, srco}, exp_src);
        end
        if (!rn) begin
            q.delete();
            in_run  = 1'b0;
            exp_us  = 0;
            exp_ud  = 0;
            exp_ue  = 0;
            exp_src = 0;
            exp_rej = 0;
            chk_en  = 1'b1;
        end else begin
            end_run = in_run && cyc >= launch_cyc + 2 && dn;
            if (pop) begin
                ent        = q.pop_front();
                exp_us     = ent.s;
                exp_ud     = ent.d;
                exp_ue     = ent.e;
                exp_src    = cfg;
                in_run     = 1'b1;
                launch_cyc = cyc + 1;
            end else if (end_run) begin
                in_run = 1'b0;
            end
            if (v && ready) begin
                if (s == d || s >= NODES || d >= NODES) begin
                    if (exp_rej < 16'hFFFF) exp_rej++;
                end else if (hit) begin
                    q[$].e = e;
                end else begin
                    ent.s = s;
                    ent.d = d;
                    ent.e = e;
                    q.push_back(ent);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit dn);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, dn, 1'b1);
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_src   = '0;
        wr_if.wr_dst   = '0;
        wr_if.wr_e     = '0;
        done           = 1'b0;
        rstn           = 1'b0;
        src_cfg        = '0;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        chk_en   = 1'b0;
        in_run   = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Single update, launch latency and completion
        step(1'b1, 1, 2, -5, 1'b0, 1'b1);
        idle(20, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        idle(6, 1'b0);

        // Overfill the FIFO during a run, then drain
        step(1'b1, 10, 11, 100, 1'b0, 1'b1);
        idle(3, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, i, i + 1, i * 7, 1'b0, 1'b1);
        idle(50, 1'b1);
        idle(4, 1'b0);

        // Rejected writes
        step(1'b1, 3, 3, 1, 1'b0, 1'b1);
        step(1'b1, 7, 7, 2, 1'b0, 1'b1);
        idle(4, 1'b0);

        // Done already high before launch
        step(1'b1, 2, 3, 50, 1'b1, 1'b1);
        step(1'b1, 4, 6, 60, 1'b1, 1'b1);
        idle(14, 1'b1);
        idle(3, 1'b0);

        // Reset while waiting with entries queued
        step(1'b1, 1, 5, 1, 1'b0, 1'b1);
        idle(4, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 20 + i, 2, i, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        idle(10, 1'b0);

        // Same pair written twice while busy
        step(1'b1, 9, 10, 0, 1'b0, 1'b1);
        idle(3, 1'b0);
        step(1'b1, 4, 5, 10, 1'b0, 1'b1);
        step(1'b1, 4, 5, 20, 1'b0, 1'b1);
        idle(30, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(1'b1 & $urandom_range(0, 1),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5)),
                 int'($urandom),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 399) != 0);
        end
        idle(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
